// File: rtl/divu_seq_if.sv
// divu_seq_if -- request/response handshake bundle for the sequential divider.
//
// Request side (master drives):  i_valid, i_dividend, i_divisor, i_signed
// Response side (master drives): i_ready
// Divider side (slave drives):   o_ready, o_valid, o_quotient, o_remainder,
//                                o_div_zero
//
// The slave modport is the divider, the master modport is the issue logic.
interface divu_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             i_signed;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_signed, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_div_zero
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_signed, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_div_zero
    );
endinterface

// File: rtl/divu_seq.sv
// divu_seq -- multi-cycle restoring integer divider, unsigned or signed
// (truncating), BITS_PER_CYCLE quotient bits retired per clock.
//
// Parameters:
//   WIDTH          operand/result width (>= 2)
//   BITS_PER_CYCLE quotient bits per clock; must divide WIDTH
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset; aborts any operation in progress
//   bus    divu_seq_if.slave handshake bundle (request in, result out)
//
// Operation: a request is accepted in IDLE, the operands are reduced to
// magnitudes, WIDTH/BITS_PER_CYCLE BUSY cycles run the restoring steps and the
// signs are re-applied on the last one. The result is held in DONE until the
// consumer takes it. A zero divisor skips BUSY and returns all-ones quotient
// with the original dividend as the remainder.
module divu_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    divu_seq_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] dvd_reg;      // dividend magnitude, shifted left each step
    logic [WIDTH-1:0] dvs_reg;      // divisor magnitude
    logic [WIDTH-1:0] rem_reg;      // partial remainder, then final remainder
    logic [WIDTH-1:0] quo_reg;      // partial quotient, then final quotient
    logic [CW-1:0]    cnt_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div_zero_reg;

    // Operand magnitudes at accept time
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    assign dvd_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
    assign dvs_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
    assign dvd_mag = dvd_neg ? -bus.i_dividend : bus.i_dividend;
    assign dvs_mag = dvs_neg ? -bus.i_divisor  : bus.i_divisor;

    // Chained restoring steps for one clock
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic             q_bit;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] d_work;
    logic [WIDTH-1:0] q_work;

    always_comb begin
        r_shift = '0;
        r_diff  = '0;
        q_bit   = 1'b0;
        r_work  = rem_reg;
        d_work  = dvd_reg;
        q_work  = quo_reg;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            // Remainder is kept below the divisor, so the shifted value fits in
            // WIDTH+1 bits; a shifted-out 1 is preserved in r_shift[WIDTH].
            r_shift = {r_work, d_work[WIDTH-1]};
            r_diff  = r_shift - {1'b0, dvs_reg};
            // r_shift < 2*divisor, so no borrow out of the MSB <=> r_shift >= divisor
            q_bit   = ~r_diff[WIDTH];
            r_work  = q_bit ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
            d_work  = {d_work[WIDTH-2:0], 1'b0};
            q_work  = {q_work[WIDTH-2:0], q_bit};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            dvd_reg      <= '0;
            dvs_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_valid) begin
                        dvd_reg   <= dvd_mag;
                        dvs_reg   <= dvs_mag;
                        neg_q_reg <= dvd_neg ^ dvs_neg;
                        neg_r_reg <= dvd_neg;
                        cnt_reg   <= CW'(N);
                        if (bus.i_divisor == '0) begin
                            quo_reg      <= '1;
                            rem_reg      <= bus.i_dividend;
                            div_zero_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            quo_reg      <= '0;
                            rem_reg      <= '0;
                            div_zero_reg <= 1'b0;
                            state_reg    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    dvd_reg <= d_work;
                    if (cnt_reg == CW'(1)) begin
                        quo_reg   <= neg_q_reg ? -q_work : q_work;
                        rem_reg   <= neg_r_reg ? -r_work : r_work;
                        state_reg <= DONE;
                    end else begin
                        quo_reg <= q_work;
                        rem_reg <= r_work;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_ready     = (state_reg == IDLE);
    assign bus.o_valid     = (state_reg == DONE);
    assign bus.o_quotient  = quo_reg;
    assign bus.o_remainder = rem_reg;
    assign bus.o_div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq -- self-checking bench for divu_seq.
// Directed table and corner sequences on a WIDTH=32/BPC=1 instance, plus a
// random sweep over WIDTH {8,32} x BPC {1,2,4,8} against an arithmetic model.
module tb_divu_seq;
    localparam int SWEEP_OPS = 400;   // per mode, per configuration

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_count  = 0;
    logic rst_main;
    logic rst_sweep;
    logic sweep_go = 1'b0;

    divu_seq_if #(.WIDTH(32)) bus ();
    divu_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .i_clk (clk),
        .i_rst (rst_main),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mark_done();
        done_count++;
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic sgn, output logic [63:0] q,
                                    output logic [63:0] r, output logic dz);
        logic [63:0] mask;
        longint sa, sb, qq, rr;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            q  = mask;
            r  = a;
            dz = 1'b1;
            return;
        end
        dz = 1'b0;
        if (sgn) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            qq = sa / sb;
            rr = sa % sb;
            q  = 64'(qq) & mask;
            r  = 64'(rr) & mask;
        end else begin
            q = (a / b) & mask;
            r = (a % b) & mask;
        end
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return mask;
            3: return 64'd1 << (w - 1);
            4: return 64'($urandom_range(0, 9));
            5: return mask - 64'($urandom_range(0, 3));
            default: return {$urandom(), $urandom()} & mask;
        endcase
    endfunction

    // Issue one request on the main DUT (called at posedge+1 in IDLE).
    // Latency = posedges from the accept edge (inclusive) until o_valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        bus.i_valid    = 1'b1;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_signed   = s;
        @(posedge clk); #1;
        // scramble inputs after acceptance; the divider must ignore them
        bus.i_valid    = 1'b0;
        bus.i_dividend = $urandom();
        bus.i_divisor  = $urandom();
        bus.i_signed   = ~s;
        lat = 1;
        while (!bus.o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = bus.o_quotient;
        r  = bus.o_remainder;
        dz = bus.o_div_zero;
        if (bus.i_ready) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    initial begin : main
        vec_t tbl[10];
        logic [31:0] q, r;
        logic        dz;
        int          lat;

        tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33};
        tbl[1] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 33};
        tbl[2] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
        tbl[3] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33};
        tbl[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33};
        tbl[5] = '{32'd1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'd1234,       1'b1, 1};
        tbl[6] = '{32'd1234,       32'd0,          1'b1, 32'hFFFFFFFF,   32'd1234,       1'b1, 1};
        tbl[7] = '{32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 1};
        tbl[8] = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, 33};
        tbl[9] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0, 33};

        rst_main       = 1'b1;
        rst_sweep      = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_signed   = 1'b0;
        bus.i_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_q",     64'(bus.o_quotient), 64'd0);
        check("rst_r",     64'(bus.o_remainder), 64'd0);
        check("rst_dz",    64'(bus.o_div_zero), 64'd0);
        rst_main  = 1'b0;
        rst_sweep = 1'b0;
        sweep_go  = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, q, r, dz, lat);
            $display("vec %0d: %h / %h signed=%0d -> q=%h r=%h dz=%0d lat=%0d",
                     i, tbl[i].a, tbl[i].b, tbl[i].s, q, r, dz, lat);
            check($sformatf("tbl%0d_q", i),   64'(q),   64'(tbl[i].q));
            check($sformatf("tbl%0d_r", i),   64'(r),   64'(tbl[i].r));
            check($sformatf("tbl%0d_dz", i),  64'(dz),  64'(tbl[i].dz));
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end

        // Back-pressure: hold result 10 cycles while a new request is offered
        bus.i_ready = 1'b0;
        run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat);
        check("bp_lat", 64'(lat), 64'd33);
        bus.i_valid    = 1'b1;
        bus.i_dividend = 32'd50;
        bus.i_divisor  = 32'd5;
        bus.i_signed   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(bus.o_valid),     64'd1);
            check("bp_ready", 64'(bus.o_ready),     64'd0);
            check("bp_q",     64'(bus.o_quotient),  64'd14);
            check("bp_r",     64'(bus.o_remainder), 64'd2);
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", 64'(bus.o_valid), 64'd0);
        check("bp_hs_ready", 64'(bus.o_ready), 64'd1);
        run_op(32'd50, 32'd5, 1'b0, q, r, dz, lat);
        $display("backpressure follow-up: 50 / 5 -> q=%h r=%h lat=%0d", q, r, lat);
        check("bp_next_q",   64'(q),   64'd10);
        check("bp_next_r",   64'(r),   64'd0);
        check("bp_next_lat", 64'(lat), 64'd33);

        // Reset on the 5th BUSY cycle
        bus.i_valid    = 1'b1;
        bus.i_dividend = 32'd1000;
        bus.i_divisor  = 32'd3;
        bus.i_signed   = 1'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_busy_ready", 64'(bus.o_ready), 64'd0);
        rst_main = 1'b1;
        @(posedge clk); #1;
        rst_main = 1'b0;
        check("mid_rst_ready", 64'(bus.o_ready),     64'd1);
        check("mid_rst_valid", 64'(bus.o_valid),     64'd0);
        check("mid_rst_q",     64'(bus.o_quotient),  64'd0);
        check("mid_rst_r",     64'(bus.o_remainder), 64'd0);
        check("mid_rst_dz",    64'(bus.o_div_zero),  64'd0);
        run_op(32'd50, 32'd5, 1'b0, q, r, dz, lat);
        $display("after reset: 50 / 5 -> q=%h r=%h lat=%0d", q, r, lat);
        check("post_rst_q",   64'(q),   64'd10);
        check("post_rst_r",   64'(r),   64'd0);
        check("post_rst_lat", 64'(lat), 64'd33);

        // Wait for the random sweep, bounded
        for (int t = 0; t < 60000 && done_count < 8; t++) @(posedge clk);
        check("sweep_complete", 64'(done_count), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Random sweep: one DUT per (WIDTH, BPC) configuration, run in parallel
    for (genvar gi = 0; gi < 8; gi++) begin : g_sweep
        localparam int W = (gi < 4) ? 8 : 32;
        localparam int B = 1 << (gi % 4);
        localparam int N = W / B;

        divu_seq_if #(.WIDTH(W)) sbus ();
        divu_seq #(.WIDTH(W), .BITS_PER_CYCLE(B)) sdut (
            .i_clk (clk),
            .i_rst (rst_sweep),
            .bus   (sbus)
        );

        initial begin : drive
            logic [63:0] a, b, eq, er;
            logic        edz;
            int          lat;
            string       tag;
            sbus.i_valid    = 1'b0;
            sbus.i_dividend = '0;
            sbus.i_divisor  = '0;
            sbus.i_signed   = 1'b0;
            sbus.i_ready    = 1'b1;
            tag = $sformatf("w%0d_bpc%0d", W, B);
            wait (sweep_go);
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < SWEEP_OPS; k++) begin
                    a = pick(W);
                    b = pick(W);
                    ref_div(W, a, b, m[0], eq, er, edz);
                    sbus.i_valid    = 1'b1;
                    sbus.i_dividend = W'(a);
                    sbus.i_divisor  = W'(b);
                    sbus.i_signed   = m[0];
                    @(posedge clk); #1;
                    sbus.i_valid    = 1'b0;
                    sbus.i_dividend = W'({$urandom(), $urandom()});
                    sbus.i_divisor  = W'({$urandom(), $urandom()});
                    lat = 1;
                    while (!sbus.o_valid && lat < N + 10) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check({tag, "_q"},   64'(sbus.o_quotient),  eq);
                    check({tag, "_r"},   64'(sbus.o_remainder), er);
                    check({tag, "_dz"},  64'(sbus.o_div_zero),  64'(edz));
                    check({tag, "_lat"}, 64'(lat), edz ? 64'd1 : 64'(N + 1));
                    @(posedge clk); #1;
                end
            end
            $display("sweep %s: %0d operations done", tag, 2 * SWEEP_OPS);
            mark_done();
        end
    end

endmodule
